// File: rtl/fb_scan_arbiter.sv
// Single-port framebuffer arbiter: prefetches each display row into a ping-pong
// line buffer for scanout and gives the CPU the RAM in the remaining line cycles.
module fb_scan_arbiter #(
    parameter int H_ACTIVE = 320,
    parameter int V_ACTIVE = 288,
    parameter int WORDS    = 20,
    parameter int ADDR_W   = 13
) (
    input  logic              clk_core_12288,
    input  logic              reset_n,
    input  logic              video_hs,
    input  logic [9:0]        visible_x,
    input  logic [9:0]        visible_y,
    output logic              pixel_state,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [15:0]       cpu_wdata,
    output logic              cpu_ack,
    output logic [15:0]       cpu_rdata,
    output logic [ADDR_W-1:0] fb_addr,
    output logic              fb_rd,
    output logic              fb_we,
    output logic [15:0]       fb_wdata,
    input  logic [15:0]       fb_rdata,
    output logic              fetch_overrun
);

    localparam int              CNT_W = $clog2(WORDS);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WORDS - 1);
    localparam logic [9:0]      H_LIM = 10'(H_ACTIVE);
    localparam logic [9:0]      V_LIM = 10'(V_ACTIVE);

    typedef enum logic [1:0] {IDLE, FETCH, FTAIL, CPU} state_t;

    state_t            state;
    logic [15:0]       line_buf [2][WORDS];
    logic              front_sel;
    logic [1:0]        buf_valid;
    logic              fetch_pending;
    logic [ADDR_W-1:0] fetch_base;
    logic [CNT_W-1:0]  word_cnt;
    logic              cpu_phase;
    logic              ack_read;
    logic [15:0]       rdata_hold;

    logic [9:0]        next_row;
    logic              row_visible;
    logic [ADDR_W-1:0] next_base;
    logic              grant;
    logic              cap_en;
    logic [CNT_W-1:0]  cap_idx;
    logic [15:0]       pixel_word;

    // Row base = row*20 built from two shifts.
    assign next_row    = visible_y + 10'd1;
    assign row_visible = next_row < V_LIM;
    assign next_base   = (ADDR_W'(next_row) << 4) + (ADDR_W'(next_row) << 2);

    // A line start in the same cycle counts as a pending fetch, so video wins the tie.
    assign grant = cpu_req && !fetch_pending && !video_hs && (state == IDLE || state == FTAIL);

    // Read data is forwarded straight from the RAM during the ack cycle, then held.
    assign cpu_rdata = ack_read ? fb_rdata : rdata_hold;

    always_comb begin
        pixel_word = '0;
        if (visible_x < H_LIM)
            pixel_word = line_buf[front_sel][visible_x[CNT_W+3:4]];
        pixel_state = buf_valid[front_sel] && (visible_x < H_LIM) && pixel_word[visible_x[3:0]];
    end

    always_comb begin
        cap_en  = 1'b0;
        cap_idx = '0;
        if (!video_hs) begin
            if (state == FETCH && word_cnt != '0) begin
                cap_en  = 1'b1;
                cap_idx = word_cnt - CNT_W'(1);
            end else if (state == FTAIL) begin
                cap_en  = 1'b1;
                cap_idx = LAST;
            end
        end
    end

    // NOTE: the line buffers are plain storage guarded by buf_valid, so they carry no reset.
    always_ff @(posedge clk_core_12288) begin
        if (cap_en)
            line_buf[~front_sel][cap_idx] <= fb_rdata;
    end

    always_ff @(posedge clk_core_12288 or negedge reset_n) begin
        if (!reset_n) begin
            state         <= IDLE;
            front_sel     <= 1'b0;
            buf_valid     <= '0;
            fetch_pending <= 1'b0;
            fetch_base    <= '0;
            word_cnt      <= '0;
            cpu_phase     <= 1'b0;
            ack_read      <= 1'b0;
            rdata_hold    <= '0;
            fb_addr       <= '0;
            fb_rd         <= 1'b0;
            fb_we         <= 1'b0;
            fb_wdata      <= '0;
            cpu_ack       <= 1'b0;
            fetch_overrun <= 1'b0;
        end else begin
            cpu_ack       <= 1'b0;
            fetch_overrun <= 1'b0;

            if (video_hs) begin
                front_sel            <= ~front_sel;
                buf_valid[front_sel] <= 1'b0;
                fetch_pending        <= row_visible;
                fetch_base           <= next_base;
            end

            case (state)
                IDLE: begin
                    if (!video_hs && fetch_pending) begin
                        state         <= FETCH;
                        fetch_pending <= 1'b0;
                        word_cnt      <= '0;
                        fb_addr       <= fetch_base;
                        fb_rd         <= 1'b1;
                    end
                end
                FETCH: begin
                    if (video_hs) begin
                        fetch_overrun <= 1'b1;
                        fb_rd         <= 1'b0;
                        state         <= IDLE;
                    end else if (word_cnt == LAST) begin
                        fb_rd <= 1'b0;
                        state <= FTAIL;
                    end else begin
                        word_cnt <= word_cnt + CNT_W'(1);
                        fb_addr  <= fb_addr + ADDR_W'(1);
                    end
                end
                FTAIL: begin
                    if (video_hs) begin
                        fetch_overrun <= 1'b1;
                    end else begin
                        buf_valid[~front_sel] <= 1'b1;
                    end
                    state <= IDLE;
                end
                CPU: begin
                    if (!cpu_phase) begin
                        fb_rd     <= 1'b0;
                        fb_we     <= 1'b0;
                        cpu_ack   <= 1'b1;
                        ack_read  <= fb_rd;
                        cpu_phase <= 1'b1;
                    end else begin
                        if (ack_read)
                            rdata_hold <= fb_rdata;
                        ack_read  <= 1'b0;
                        cpu_phase <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase

            // A grant overrides the FTAIL->IDLE step so the CPU loses no cycle after a fetch.
            if (grant) begin
                state    <= CPU;
                fb_addr  <= cpu_addr;
                fb_wdata <= cpu_wdata;
                fb_we    <= cpu_we;
                fb_rd    <= ~cpu_we;
            end
        end
    end

endmodule

// File: tb/tb_fb_scan_arbiter.sv
// Self-checking bench for fb_scan_arbiter: RAM model, table-driven pixel checks,
// hand-written timing sequences and randomized traffic against a shadow memory.
module tb_fb_scan_arbiter;

    localparam int ADDR_W = 13;

    logic              clk_core_12288 = 1'b0;
    logic              reset_n;
    logic              video_hs;
    logic [9:0]        visible_x;
    logic [9:0]        visible_y;
    logic              pixel_state;
    logic              cpu_req;
    logic              cpu_we;
    logic [ADDR_W-1:0] cpu_addr;
    logic [15:0]       cpu_wdata;
    logic              cpu_ack;
    logic [15:0]       cpu_rdata;
    logic [ADDR_W-1:0] fb_addr;
    logic              fb_rd;
    logic              fb_we;
    logic [15:0]       fb_wdata;
    logic [15:0]       fb_rdata = '0;
    logic              fetch_overrun;

    logic [15:0] ram     [8192];
    logic [15:0] ref_mem [8192];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [9:0] x;
        logic       exp;
    } pix_vec_t;

    pix_vec_t vecs [9];

    fb_scan_arbiter dut (
        .clk_core_12288(clk_core_12288),
        .reset_n       (reset_n),
        .video_hs      (video_hs),
        .visible_x     (visible_x),
        .visible_y     (visible_y),
        .pixel_state   (pixel_state),
        .cpu_req       (cpu_req),
        .cpu_we        (cpu_we),
        .cpu_addr      (cpu_addr),
        .cpu_wdata     (cpu_wdata),
        .cpu_ack       (cpu_ack),
        .cpu_rdata     (cpu_rdata),
        .fb_addr       (fb_addr),
        .fb_rd         (fb_rd),
        .fb_we         (fb_we),
        .fb_wdata      (fb_wdata),
        .fb_rdata      (fb_rdata),
        .fetch_overrun (fetch_overrun)
    );

    always #40 clk_core_12288 = ~clk_core_12288;

    // Synchronous single-port RAM, read data one cycle after fb_rd.
    always @(posedge clk_core_12288) begin
        if (fb_we) ram[fb_addr] <= fb_wdata;
        if (fb_rd) fb_rdata <= ram[fb_addr];
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input int addr, input logic [15:0] data);
        ram[addr]     = data;
        ref_mem[addr] = data;
    endtask

    task automatic pulse_hs(input logic [9:0] y);
        @(negedge clk_core_12288);
        visible_y = y;
        video_hs  = 1'b1;
        @(negedge clk_core_12288);
        video_hs = 1'b0;
    endtask

    task automatic cpu_xfer(input logic we, input logic [12:0] addr, input logic [15:0] wd,
                            output logic [15:0] rd, output int lat);
        @(negedge clk_core_12288);
        cpu_req   = 1'b1;
        cpu_we    = we;
        cpu_addr  = addr;
        cpu_wdata = wd;
        lat = 0;
        rd  = '0;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clk_core_12288);
            if (cpu_ack) begin
                lat = n;
                rd  = cpu_rdata;
                break;
            end
        end
        cpu_req = 1'b0;
        if (we) ref_mem[addr] = wd;
    endtask

    // Expected pixel of row r at column x, straight from the shadow memory.
    function automatic logic ref_pixel(input int r, input int x);
        logic [15:0] w;
        if (x >= 320) return 1'b0;
        w = ref_mem[r * 20 + x / 16];
        return w[x % 16];
    endfunction

    initial begin
        logic [15:0] rd;
        int          lat;
        int          ack_n;
        logic [12:0] pool [8];

        vecs[0] = '{10'd0,    1'b1};
        vecs[1] = '{10'd1,    1'b0};
        vecs[2] = '{10'd2,    1'b1};
        vecs[3] = '{10'd3,    1'b0};
        vecs[4] = '{10'd16,   1'b0};
        vecs[5] = '{10'd318,  1'b0};
        vecs[6] = '{10'd319,  1'b1};
        vecs[7] = '{10'd320,  1'b0};
        vecs[8] = '{10'd1023, 1'b0};

        for (int i = 0; i < 8192; i++) preload(i, 16'h0000);
        reset_n   = 1'b0;
        video_hs  = 1'b0;
        visible_x = '0;
        visible_y = '0;
        cpu_req   = 1'b0;
        cpu_we    = 1'b0;
        cpu_addr  = '0;
        cpu_wdata = '0;

        // Reset state
        repeat (3) @(negedge clk_core_12288);
        check("rst_pixel", pixel_state, 1'b0);
        check("rst_fb", {fb_rd, fb_we, fb_addr, fb_wdata}, '0);
        check("rst_cpu", {cpu_ack, cpu_rdata, fetch_overrun}, '0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk_core_12288);

        // Scanout of row 0 through a swap, table-driven pixel checks
        preload(0, 16'h0005);
        preload(19, 16'h8000);
        for (int w = 0; w < 20; w++) preload(20 + w, 16'($urandom));
        pulse_hs(10'd1023);
        repeat (24) @(negedge clk_core_12288);
        pulse_hs(10'd0);
        foreach (vecs[i]) begin
            visible_x = vecs[i].x;
            #1;
            check($sformatf("pix_tab_x%0d", vecs[i].x), pixel_state, vecs[i].exp);
        end
        repeat (25) @(negedge clk_core_12288);

        // CPU write timing, then read back
        @(negedge clk_core_12288);
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h0014; cpu_wdata = 16'hA5A5;
        @(negedge clk_core_12288);
        check("wr_c1_we", {fb_we, fb_rd, cpu_ack}, 3'b100);
        check("wr_c1_addr", fb_addr, 13'h0014);
        check("wr_c1_data", fb_wdata, 16'hA5A5);
        @(negedge clk_core_12288);
        check("wr_c2_ack", {cpu_ack, fb_we}, 2'b10);
        cpu_req = 1'b0;
        ref_mem[13'h0014] = 16'hA5A5;
        cpu_xfer(1'b0, 13'h0014, 16'h0000, rd, lat);
        check("rd_lat", lat, 2);
        check("rd_data", rd, 16'hA5A5);
        @(negedge clk_core_12288);
        check("rd_hold", cpu_rdata, 16'hA5A5);

        // Priority: line start and CPU request in the same cycle
        @(negedge clk_core_12288);
        video_hs = 1'b1; visible_y = 10'd4;
        cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 13'h1F00; cpu_wdata = 16'h1234;
        ack_n = 0;
        for (int n = 1; n <= 30 && ack_n == 0; n++) begin
            @(negedge clk_core_12288);
            video_hs = 1'b0;
            check($sformatf("pri_rd_n%0d", n), fb_rd, (n >= 2 && n <= 21));
            if (n >= 2 && n <= 21) check($sformatf("pri_addr_n%0d", n), fb_addr, 100 + n - 2);
            check($sformatf("pri_we_n%0d", n), fb_we, (n == 23));
            if (cpu_ack) begin
                ack_n   = n;
                cpu_req = 1'b0;
            end
        end
        cpu_req = 1'b0;
        ref_mem[13'h1F00] = 16'h1234;
        check("pri_ack_cycle", ack_n, 24);
        repeat (4) @(negedge clk_core_12288);

        // End of frame: row 288 is never fetched and the next line is blank
        for (int w = 0; w < 20; w++) begin
            preload(286 * 20 + w, 16'hFFFF);
            preload(287 * 20 + w, 16'hFFFF);
        end
        pulse_hs(10'd285);
        repeat (25) @(negedge clk_core_12288);
        pulse_hs(10'd286);
        repeat (25) @(negedge clk_core_12288);
        pulse_hs(10'd287);
        visible_x = 10'd5;
        #1;
        check("eof_row287_visible", pixel_state, 1'b1);
        lat = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk_core_12288);
            if (fb_rd) lat++;
        end
        check("eof_no_fetch", lat, 0);
        pulse_hs(10'd1023);
        lat = 0;
        for (int x = 0; x < 320; x += 7) begin
            visible_x = 10'(x);
            #1;
            if (pixel_state) lat++;
        end
        check("eof_blank_line", lat, 0);
        repeat (25) @(negedge clk_core_12288);

        // Overrun: second line start 10 cycles into a fetch
        preload(200, 16'hFFFF);
        for (int w = 0; w < 20; w++) preload(400 + w, 16'($urandom));
        @(negedge clk_core_12288);
        video_hs = 1'b1; visible_y = 10'd9;
        visible_x = 10'd0;
        for (int n = 1; n <= 34; n++) begin
            @(negedge clk_core_12288);
            check($sformatf("ovr_pulse_n%0d", n), fetch_overrun, (n == 11));
            check($sformatf("ovr_rd_n%0d", n), fb_rd, ((n >= 2 && n <= 10) || (n >= 12 && n <= 31)));
            if (n >= 2 && n <= 10) check($sformatf("ovr_a1_n%0d", n), fb_addr, 200 + n - 2);
            if (n >= 12 && n <= 31) check($sformatf("ovr_a2_n%0d", n), fb_addr, 400 + n - 12);
            if (n >= 12 && n <= 33) check($sformatf("ovr_partial_n%0d", n), pixel_state, 1'b0);
            video_hs = (n == 10 || n == 33);
            if (n == 10) visible_y = 10'd19;
            if (n == 33) visible_y = 10'd20;
        end
        for (int i = 0; i < 10; i++) begin
            int x = $urandom_range(0, 330);
            visible_x = 10'(x);
            #1;
            check($sformatf("ovr_row20_x%0d", x), pixel_state, ref_pixel(20, x));
        end
        repeat (25) @(negedge clk_core_12288);

        // Randomized CPU traffic against the shadow memory
        foreach (pool[i]) pool[i] = 13'($urandom_range(0, 8191));
        for (int i = 0; i < 30; i++) begin
            logic        we   = 1'($urandom);
            logic [12:0] a    = pool[$urandom_range(0, 7)];
            logic [15:0] wd   = 16'($urandom);
            logic [15:0] expd = ref_mem[a];
            cpu_xfer(we, a, wd, rd, lat);
            check($sformatf("rnd_lat_%0d", i), lat, 2);
            if (!we) check($sformatf("rnd_rd_%0d", i), rd, expd);
        end

        // Randomized scanout: rows written via the CPU, pixels checked after a swap
        for (int k = 0; k < 3; k++) begin
            int r = $urandom_range(1, 287);
            for (int w = 0; w < 20; w++) cpu_xfer(1'b1, 13'(r * 20 + w), 16'($urandom), rd, lat);
            pulse_hs(10'(r - 1));
            repeat (24) @(negedge clk_core_12288);
            pulse_hs(10'(r));
            for (int i = 0; i < 12; i++) begin
                int x = $urandom_range(0, 400);
                visible_x = 10'(x);
                #1;
                check($sformatf("rnd_pix_r%0d_x%0d", r, x), pixel_state, ref_pixel(r, x));
            end
            repeat (25) @(negedge clk_core_12288);
        end

        // Reset asserted in the middle of a fetch
        pulse_hs(10'd49);
        repeat (4) @(negedge clk_core_12288);
        check("mid_fetch_rd", fb_rd, 1'b1);
        #5 reset_n = 1'b0;
        #1;
        check("arst_fb", {fb_rd, fb_we, fb_addr, fb_wdata}, '0);
        check("arst_cpu", {cpu_ack, cpu_rdata, fetch_overrun}, '0);
        check("arst_pixel", pixel_state, 1'b0);
        @(negedge clk_core_12288);
        reset_n = 1'b1;
        visible_x = 10'd0;
        #1;
        check("post_rst_pixel", pixel_state, 1'b0);
        cpu_xfer(1'b0, 13'h0014, 16'h0000, rd, lat);
        check("post_rst_lat", lat, 2);
        check("post_rst_rd", rd, ref_mem[13'h0014]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
